// File: rtl/hazard_track_unit.sv
// Stall/forwarding controller for the five-stage MIPS pipeline, driven by shadow E/M/W write state.
// Optional multiply/divide busy tracking is compiled in when HAZARD_MD_EN is defined.
module hazard_track_unit #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] D_rs_addr,
    input  logic [REG_AW-1:0] D_rt_addr,
    input  logic [1:0]        D_tuse_rs,
    input  logic [1:0]        D_tuse_rt,
    input  logic              D_rfwr,
    input  logic [REG_AW-1:0] D_rfdst,
    input  logic [1:0]        D_tnew,
    input  logic              D_md_use,
    input  logic              D_md_start,
    input  logic              D_md_div,
    output logic              stall,
    output logic              E_bubble,
    output logic [1:0]        fwd_D_rs,
    output logic [1:0]        fwd_D_rt,
    output logic [1:0]        fwd_E_rs,
    output logic [1:0]        fwd_E_rt,
    output logic [1:0]        fwd_M_rt,
    output logic              md_busy
);

    localparam int unsigned MD_W = $clog2(DIV_CYCLES + 1);

    logic              r_e_wr, r_m_wr, r_w_wr;
    logic [REG_AW-1:0] r_e_dst, r_m_dst, r_w_dst;
    logic [1:0]        r_e_tnew, r_m_tnew;
    logic [REG_AW-1:0] r_e_rs, r_e_rt, r_m_rt;

    logic w_e_hit_rs, w_m_hit_rs, w_w_hit_rs;
    logic w_e_hit_rt, w_m_hit_rt, w_w_hit_rt;
    logic w_me_hit_rs, w_we_hit_rs, w_me_hit_rt, w_we_hit_rt, w_wm_hit_rt;
    logic w_reg_stall, w_md_stall, w_stall;

    // A stage hazards a source when it writes that register and the register is not $0.
    function automatic logic hit(input logic wr, input logic [REG_AW-1:0] dst,
                                 input logic [REG_AW-1:0] src);
        hit = wr && (dst == src) && (src != '0);
    endfunction

    // Nearest hazarding stage wins; a not-yet-ready nearest writer yields 0 (stall covers it).
    function automatic logic [1:0] pick(input logic he, input logic [1:0] te,
                                        input logic hm, input logic [1:0] tm,
                                        input logic hw);
        pick = 2'd0;
        if (he)      pick = (te == 2'd0) ? 2'd1 : 2'd0;
        else if (hm) pick = (tm == 2'd0) ? 2'd2 : 2'd0;
        else if (hw) pick = 2'd3;
    endfunction

    always_comb begin
        w_e_hit_rs  = hit(r_e_wr, r_e_dst, D_rs_addr);
        w_m_hit_rs  = hit(r_m_wr, r_m_dst, D_rs_addr);
        w_w_hit_rs  = hit(r_w_wr, r_w_dst, D_rs_addr);
        w_e_hit_rt  = hit(r_e_wr, r_e_dst, D_rt_addr);
        w_m_hit_rt  = hit(r_m_wr, r_m_dst, D_rt_addr);
        w_w_hit_rt  = hit(r_w_wr, r_w_dst, D_rt_addr);
        w_me_hit_rs = hit(r_m_wr, r_m_dst, r_e_rs);
        w_we_hit_rs = hit(r_w_wr, r_w_dst, r_e_rs);
        w_me_hit_rt = hit(r_m_wr, r_m_dst, r_e_rt);
        w_we_hit_rt = hit(r_w_wr, r_w_dst, r_e_rt);
        w_wm_hit_rt = hit(r_w_wr, r_w_dst, r_m_rt);

        w_reg_stall = (w_e_hit_rs && (D_tuse_rs < r_e_tnew))
                   || (w_m_hit_rs && (D_tuse_rs < r_m_tnew))
                   || (w_e_hit_rt && (D_tuse_rt < r_e_tnew))
                   || (w_m_hit_rt && (D_tuse_rt < r_m_tnew));
        w_stall     = w_reg_stall || w_md_stall;

        // W always holds a finished result, so its Tnew is zero by construction.
        fwd_D_rs = pick(w_e_hit_rs, r_e_tnew, w_m_hit_rs, r_m_tnew, w_w_hit_rs);
        fwd_D_rt = pick(w_e_hit_rt, r_e_tnew, w_m_hit_rt, r_m_tnew, w_w_hit_rt);
        fwd_E_rs = pick(1'b0, 2'd0, w_me_hit_rs, r_m_tnew, w_we_hit_rs);
        fwd_E_rt = pick(1'b0, 2'd0, w_me_hit_rt, r_m_tnew, w_we_hit_rt);
        fwd_M_rt = w_wm_hit_rt ? 2'd3 : 2'd0;
    end

    assign stall    = w_stall;
    assign E_bubble = w_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e_wr   <= 1'b0;
            r_e_dst  <= '0;
            r_e_tnew <= 2'd0;
            r_e_rs   <= '0;
            r_e_rt   <= '0;
            r_m_wr   <= 1'b0;
            r_m_dst  <= '0;
            r_m_tnew <= 2'd0;
            r_m_rt   <= '0;
            r_w_wr   <= 1'b0;
            r_w_dst  <= '0;
        end else begin
            if (w_stall) begin
                r_e_wr   <= 1'b0;
                r_e_dst  <= '0;
                r_e_tnew <= 2'd0;
                r_e_rs   <= '0;
                r_e_rt   <= '0;
            end else begin
                r_e_wr   <= D_rfwr;
                r_e_dst  <= D_rfdst;
                r_e_tnew <= D_tnew;
                r_e_rs   <= D_rs_addr;
                r_e_rt   <= D_rt_addr;
            end
            r_m_wr   <= r_e_wr;
            r_m_dst  <= r_e_dst;
            r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
            r_m_rt   <= r_e_rt;
            r_w_wr   <= r_m_wr;
            r_w_dst  <= r_m_dst;
        end
    end

`ifdef HAZARD_MD_EN
    logic            r_e_md_start, r_e_md_div;
    logic [MD_W-1:0] r_md_cnt;

    // Counter loads as the MD op leaves E and runs down to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
            r_md_cnt     <= '0;
        end else begin
            r_e_md_start <= w_stall ? 1'b0 : D_md_start;
            r_e_md_div   <= w_stall ? 1'b0 : D_md_div;
            if (r_e_md_start)
                r_md_cnt <= r_e_md_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
            else if (r_md_cnt != '0)
                r_md_cnt <= r_md_cnt - MD_W'(1);
        end
    end

    assign md_busy    = (r_md_cnt != '0);
    assign w_md_stall = D_md_use && (md_busy || r_e_md_start);
`else
    logic w_md_unused;
    assign w_md_unused = ^{D_md_use, D_md_start, D_md_div, MD_W'(MULT_CYCLES)};
    assign md_busy     = 1'b0;
    assign w_md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_track_unit.sv
// Directed bench for hazard_track_unit: table of pipeline vectors plus reset and MD sequences.
module tb_hazard_track_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] D_rs_addr, D_rt_addr, D_rfdst;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       D_rfwr, D_md_use, D_md_start, D_md_div;
    logic       stall, E_bubble, md_busy;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_track_unit dut (
        .clk(clk), .reset_n(reset_n),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_rfwr(D_rfwr), .D_rfdst(D_rfdst), .D_tnew(D_tnew),
        .D_md_use(D_md_use), .D_md_start(D_md_start), .D_md_div(D_md_div),
        .stall(stall), .E_bubble(E_bubble),
        .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
        .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt),
        .md_busy(md_busy)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] urs, urt;
        logic       wr;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       st;
        logic [1:0] fdrs, fdrt, fers, fert, fmrt;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(input int rs, input int rt, input int urs, input int urt,
                                input int wr, input int dst, input int tnew, input int st,
                                input int fdrs, input int fdrt, input int fers,
                                input int fert, input int fmrt);
        vec_t v;
        v.rs = 5'(rs);   v.rt = 5'(rt);   v.urs = 2'(urs); v.urt = 2'(urt);
        v.wr = 1'(wr);   v.dst = 5'(dst); v.tnew = 2'(tnew);
        v.st = 1'(st);   v.fdrs = 2'(fdrs); v.fdrt = 2'(fdrt);
        v.fers = 2'(fers); v.fert = 2'(fert); v.fmrt = 2'(fmrt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic mu, input logic ms, input logic md);
        D_rs_addr = v.rs; D_rt_addr = v.rt; D_tuse_rs = v.urs; D_tuse_rt = v.urt;
        D_rfwr = v.wr; D_rfdst = v.dst; D_tnew = v.tnew;
        D_md_use = mu; D_md_start = ms; D_md_div = md;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " stall"},    4'(stall),    4'(v.st));
        chk({tag, " E_bubble"}, 4'(E_bubble), 4'(v.st));
        chk({tag, " fwd_D_rs"}, 4'(fwd_D_rs), 4'(v.fdrs));
        chk({tag, " fwd_D_rt"}, 4'(fwd_D_rt), 4'(v.fdrt));
        chk({tag, " fwd_E_rs"}, 4'(fwd_E_rs), 4'(v.fers));
        chk({tag, " fwd_E_rt"}, 4'(fwd_E_rt), 4'(v.fert));
        chk({tag, " fwd_M_rt"}, 4'(fwd_M_rt), 4'(v.fmrt));
    endtask

    initial begin
        vec_t nop, lw1, use1, zero, mfhi;
        nop  = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw1  = mk(2, 1, 1, 3, 1, 1, 2, 0, 0, 0, 0, 0, 0);
        use1 = mk(1, 3, 1, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0);
        zero = nop;
        mfhi = mk(0, 0, 3, 3, 1, 10, 1, 0, 0, 0, 0, 0, 0);

        // lw $1 ; addu $2,$1,$3 (Tuse 1): one stall, then lw is in W when addu reaches E
        tbl[0]  = lw1;
        tbl[1]  = use1;
        tbl[2]  = mk(1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        tbl[4]  = nop;
        tbl[5]  = nop;
        // lw $1 ; beq $1,$0 (Tuse 0): two stalls, then D forwards from W
        tbl[6]  = lw1;
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        tbl[10] = nop;
        tbl[11] = nop;
        // addu $1 ; ori $1,$1 ; addu $4,$1,$1: E takes the newer writer from M
        tbl[12] = mk(2, 3, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 1, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 2, 2, 0);
        tbl[15] = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 2, 2, 3);
        tbl[16] = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        tbl[17] = nop;
        // writer to $0 never hazards
        tbl[18] = mk(2, 0, 1, 3, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        // rt load-use stall while rs forwards from M in the same cycle
        tbl[20] = mk(0, 8, 1, 3, 1, 8, 2, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(5, 8, 1, 1, 1, 9, 1, 1, 2, 0, 0, 0, 0);
        tbl[22] = mk(5, 8, 1, 1, 1, 9, 1, 0, 3, 0, 0, 0, 0);
        tbl[23] = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        tbl[24] = nop;
        tbl[25] = nop;
        tbl[26] = nop;

        // Reset: outputs quiet even with hazard-looking D inputs
        reset_n = 1'b0;
        drive(use1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk_all("reset", zero);
        chk("reset md_busy", 4'(md_busy), 4'd0);
        drive(nop, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i], 1'b0, 1'b0, 1'b0);
            #1;
            chk_all($sformatf("v%0d", i), tbl[i]);
        end

        // Asynchronous reset drops a pending load-use stall before the next edge
        @(negedge clk); drive(lw1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(use1, 1'b0, 1'b0, 1'b0); #1;
        chk("pre-reset stall", 4'(stall), 4'd1);
        reset_n = 1'b0; #1;
        chk("async reset stall", 4'(stall), 4'd0);
        chk("async reset E_bubble", 4'(E_bubble), 4'd0);
        drive(nop, 1'b0, 1'b0, 1'b0); #1;
        reset_n = 1'b1;

`ifdef HAZARD_MD_EN
        // div enters E at cycle t; mfhi waits in D until t+11
        @(negedge clk); drive(nop, 1'b1, 1'b1, 1'b1);
        @(negedge clk); drive(mfhi, 1'b1, 1'b0, 1'b0); #1;
        chk("md t stall", 4'(stall), 4'd1);
        chk("md t busy", 4'(md_busy), 4'd0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk); #1;
            chk($sformatf("md t+%0d stall", k), 4'(stall), (k <= 10) ? 4'd1 : 4'd0);
            chk($sformatf("md t+%0d busy", k), 4'(md_busy), (k <= 10) ? 4'd1 : 4'd0);
        end
        @(negedge clk); drive(nop, 1'b0, 1'b0, 1'b0);
        // Reset at t+4 of a second div aborts the count at once
        @(negedge clk); drive(nop, 1'b1, 1'b1, 1'b1);
        @(negedge clk); drive(mfhi, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        #1;
        chk("md2 t+4 busy", 4'(md_busy), 4'd1);
        chk("md2 t+4 stall", 4'(stall), 4'd1);
        reset_n = 1'b0; #1;
        chk("md2 reset busy", 4'(md_busy), 4'd0);
        chk("md2 reset stall", 4'(stall), 4'd0);
        drive(nop, 1'b0, 1'b0, 1'b0); #1;
        reset_n = 1'b1;
`else
        // Without the MD option the D_md_* inputs have no effect
        @(negedge clk); drive(nop, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(mfhi, 1'b1, 1'b0, 1'b0); #1;
            chk($sformatf("nomd %0d stall", k), 4'(stall), 4'd0);
            chk($sformatf("nomd %0d busy", k), 4'(md_busy), 4'd0);
        end
        drive(nop, 1'b0, 1'b0, 1'b0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
